// File: rtl/miriscv_decoder_pkg.sv
// Shared decoder definitions: ALU codes, operand/LSU/write-back selects,
// major opcodes and the decoded-control bundle with its reset/default value.
package miriscv_decoder_pkg;

  localparam int ALU_OP_WIDTH = 5;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 5'b00000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 5'b01000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 5'b00100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 5'b00110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 5'b00111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 5'b01101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 5'b00101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 5'b00001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS  = 5'b11100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU  = 5'b11110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GES  = 5'b11101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU  = 5'b11111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ   = 5'b11000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_NE   = 5'b11001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTS = 5'b00010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 5'b00011;

  localparam logic [1:0] OP_A_RS1     = 2'd0;
  localparam logic [1:0] OP_A_CURR_PC = 2'd1;
  localparam logic [1:0] OP_A_ZERO    = 2'd2;

  localparam logic [2:0] OP_B_RS2   = 3'd0;
  localparam logic [2:0] OP_B_IMM_I = 3'd1;
  localparam logic [2:0] OP_B_IMM_U = 3'd2;
  localparam logic [2:0] OP_B_IMM_S = 3'd3;
  localparam logic [2:0] OP_B_INCR  = 3'd4;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  localparam logic WB_EX_RESULT = 1'b0;
  localparam logic WB_LSU_DATA  = 1'b1;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef struct packed {
    logic [1:0]              op_a_sel;
    logic [2:0]              op_b_sel;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic                    mem_req;
    logic                    mem_we;
    logic [2:0]              mem_size;
    logic                    gpr_we;
    logic                    wb_src_sel;
    logic                    illegal;
    logic                    branch;
    logic                    jal;
    logic                    jalr;
  } dec_ctrl_t;

  // Quiet, legal control word: also what an illegal instruction decays to.
  function automatic dec_ctrl_t dec_default();
    dec_ctrl_t d;
    d.op_a_sel   = OP_A_RS1;
    d.op_b_sel   = OP_B_IMM_I;
    d.alu_op     = ALU_ADD;
    d.mem_req    = 1'b0;
    d.mem_we     = 1'b0;
    d.mem_size   = LDST_W;
    d.gpr_we     = 1'b0;
    d.wb_src_sel = WB_EX_RESULT;
    d.illegal    = 1'b0;
    d.branch     = 1'b0;
    d.jal        = 1'b0;
    d.jalr       = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/miriscv_decoder_if.sv
// Fetch-to-decoder bundle: instruction word in, datapath controls out.
// master = fetch/datapath side, slave = decoder.
interface miriscv_decoder_if;
  import miriscv_decoder_pkg::*;

  logic [31:0]             fetched_instr_i;
  logic [1:0]              ex_op_a_sel_o;
  logic [2:0]              ex_op_b_sel_o;
  logic [ALU_OP_WIDTH-1:0] alu_op_o;
  logic                    mem_req_o;
  logic                    mem_we_o;
  logic [2:0]              mem_size_o;
  logic                    gpr_we_a_o;
  logic                    wb_src_sel_o;
  logic                    illegal_instr_o;
  logic                    branch_o;
  logic                    jal_o;
  logic                    jalr_o;

  modport master (
    output fetched_instr_i,
    input  ex_op_a_sel_o, ex_op_b_sel_o, alu_op_o, mem_req_o, mem_we_o,
           mem_size_o, gpr_we_a_o, wb_src_sel_o, illegal_instr_o,
           branch_o, jal_o, jalr_o
  );

  modport slave (
    input  fetched_instr_i,
    output ex_op_a_sel_o, ex_op_b_sel_o, alu_op_o, mem_req_o, mem_we_o,
           mem_size_o, gpr_we_a_o, wb_src_sel_o, illegal_instr_o,
           branch_o, jal_o, jalr_o
  );

endinterface

// File: rtl/miriscv_decoder.sv
// RV32I instruction decoder. One combinational decode of the major opcode;
// with REG_OUT=1 the control word is registered (one cycle latency, reset
// to the quiet default word).
module miriscv_decoder
  import miriscv_decoder_pkg::*;
#(
  parameter bit REG_OUT = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  miriscv_decoder_if.slave  dec_if
);

  logic [31:0] w_instr;
  logic [4:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_illegal;
  logic        w_unused_bits;
  dec_ctrl_t   w_dec;
  dec_ctrl_t   w_out;
  dec_ctrl_t   r_dec;

  assign w_instr  = dec_if.fetched_instr_i;
  assign w_opcode = w_instr[6:2];
  assign w_funct3 = w_instr[14:12];
  assign w_funct7 = w_instr[31:25];

  // Register and immediate fields are consumed by the datapath, not here.
  assign w_unused_bits = ^{w_instr[24:15], w_instr[11:7]};

  // Decode the opcode into a control word; illegal encodings collapse to defaults.
  always_comb begin
    w_dec     = dec_default();
    w_illegal = 1'b0;
    if (w_instr[1:0] != 2'b11) begin
      w_illegal = 1'b1;
    end else begin
      case (w_opcode)
        OPC_LOAD: begin
          w_dec.mem_req    = 1'b1;
          w_dec.mem_size   = w_funct3;
          w_dec.gpr_we     = 1'b1;
          w_dec.wb_src_sel = WB_LSU_DATA;
          if (!(w_funct3 inside {LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU}))
            w_illegal = 1'b1;
        end
        OPC_STORE: begin
          w_dec.op_b_sel = OP_B_IMM_S;
          w_dec.mem_req  = 1'b1;
          w_dec.mem_we   = 1'b1;
          w_dec.mem_size = w_funct3;
          if (!(w_funct3 inside {LDST_B, LDST_H, LDST_W}))
            w_illegal = 1'b1;
        end
        OPC_OP_IMM: begin
          w_dec.gpr_we = 1'b1;
          case (w_funct3)
            3'd0: w_dec.alu_op = ALU_ADD;
            3'd1: begin
              w_dec.alu_op = ALU_SLL;
              if (w_funct7 != F7_BASE) w_illegal = 1'b1;
            end
            3'd2: w_dec.alu_op = ALU_SLTS;
            3'd3: w_dec.alu_op = ALU_SLTU;
            3'd4: w_dec.alu_op = ALU_XOR;
            3'd5: begin
              if (w_funct7 == F7_BASE)     w_dec.alu_op = ALU_SRL;
              else if (w_funct7 == F7_ALT) w_dec.alu_op = ALU_SRA;
              else                         w_illegal    = 1'b1;
            end
            3'd6: w_dec.alu_op = ALU_OR;
            default: w_dec.alu_op = ALU_AND;
          endcase
        end
        OPC_OP: begin
          w_dec.op_b_sel = OP_B_RS2;
          w_dec.gpr_we   = 1'b1;
          if (w_funct7 == F7_BASE) begin
            case (w_funct3)
              3'd0: w_dec.alu_op = ALU_ADD;
              3'd1: w_dec.alu_op = ALU_SLL;
              3'd2: w_dec.alu_op = ALU_SLTS;
              3'd3: w_dec.alu_op = ALU_SLTU;
              3'd4: w_dec.alu_op = ALU_XOR;
              3'd5: w_dec.alu_op = ALU_SRL;
              3'd6: w_dec.alu_op = ALU_OR;
              default: w_dec.alu_op = ALU_AND;
            endcase
          end else if (w_funct7 == F7_ALT && w_funct3 == 3'd0) begin
            w_dec.alu_op = ALU_SUB;
          end else if (w_funct7 == F7_ALT && w_funct3 == 3'd5) begin
            w_dec.alu_op = ALU_SRA;
          end else begin
            w_illegal = 1'b1;
          end
        end
        OPC_LUI: begin
          w_dec.op_a_sel = OP_A_ZERO;
          w_dec.op_b_sel = OP_B_IMM_U;
          w_dec.gpr_we   = 1'b1;
        end
        OPC_AUIPC: begin
          w_dec.op_a_sel = OP_A_CURR_PC;
          w_dec.op_b_sel = OP_B_IMM_U;
          w_dec.gpr_we   = 1'b1;
        end
        OPC_BRANCH: begin
          w_dec.op_b_sel = OP_B_RS2;
          w_dec.branch   = 1'b1;
          case (w_funct3)
            3'd0: w_dec.alu_op = ALU_EQ;
            3'd1: w_dec.alu_op = ALU_NE;
            3'd4: w_dec.alu_op = ALU_LTS;
            3'd5: w_dec.alu_op = ALU_GES;
            3'd6: w_dec.alu_op = ALU_LTU;
            3'd7: w_dec.alu_op = ALU_GEU;
            default: w_illegal = 1'b1;
          endcase
        end
        OPC_JAL: begin
          w_dec.op_a_sel = OP_A_CURR_PC;
          w_dec.op_b_sel = OP_B_INCR;
          w_dec.gpr_we   = 1'b1;
          w_dec.jal      = 1'b1;
        end
        OPC_JALR: begin
          w_dec.op_a_sel = OP_A_CURR_PC;
          w_dec.op_b_sel = OP_B_INCR;
          w_dec.gpr_we   = 1'b1;
          w_dec.jalr     = 1'b1;
          if (w_funct3 != 3'd0) w_illegal = 1'b1;
        end
        OPC_MISC_MEM, OPC_SYSTEM: ;
        default: w_illegal = 1'b1;
      endcase
    end
    if (w_illegal) begin
      w_dec         = dec_default();
      w_dec.illegal = 1'b1;
    end
  end

  // Optional output register stage; reset holds the quiet default word.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_dec <= dec_default();
    else       r_dec <= w_dec;
  end

  assign w_out = REG_OUT ? r_dec : w_dec;

  assign dec_if.ex_op_a_sel_o   = w_out.op_a_sel;
  assign dec_if.ex_op_b_sel_o   = w_out.op_b_sel;
  assign dec_if.alu_op_o        = w_out.alu_op;
  assign dec_if.mem_req_o       = w_out.mem_req;
  assign dec_if.mem_we_o        = w_out.mem_we;
  assign dec_if.mem_size_o      = w_out.mem_size;
  assign dec_if.gpr_we_a_o      = w_out.gpr_we;
  assign dec_if.wb_src_sel_o    = w_out.wb_src_sel;
  assign dec_if.illegal_instr_o = w_out.illegal;
  assign dec_if.branch_o        = w_out.branch;
  assign dec_if.jal_o           = w_out.jal;
  assign dec_if.jalr_o          = w_out.jalr;

endmodule

// File: tb/tb_miriscv_decoder.sv
// Bench for miriscv_decoder: a zero-latency instance and a registered
// instance side by side, fed the same instruction word.
module tb_miriscv_decoder;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk_i = ~clk_i;

  miriscv_decoder_if if0 ();
  miriscv_decoder_if if1 ();

  miriscv_decoder #(.REG_OUT(1'b0)) u_dut_comb (.clk_i(clk_i), .rst_i(rst_i), .dec_if(if0));
  miriscv_decoder #(.REG_OUT(1'b1)) u_dut_reg  (.clk_i(clk_i), .rst_i(rst_i), .dec_if(if1));

  // Bench-side encodings, written out independently of the design package.
  localparam logic [4:0] A_ADD = 5'b00000, A_SUB = 5'b01000, A_XOR = 5'b00100, A_OR  = 5'b00110;
  localparam logic [4:0] A_AND = 5'b00111, A_SRA = 5'b01101, A_SRL = 5'b00101, A_SLL = 5'b00001;
  localparam logic [4:0] A_LTS = 5'b11100, A_LTU = 5'b11110, A_GES = 5'b11101, A_GEU = 5'b11111;
  localparam logic [4:0] A_EQ  = 5'b11000, A_NE  = 5'b11001, A_SLTS = 5'b00010, A_SLTU = 5'b00011;
  localparam logic [4:0] BASE_TBL [8] = '{A_ADD, A_SLL, A_SLTS, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
  localparam logic [4:0] BR_TBL   [8] = '{A_EQ, A_NE, A_ADD, A_ADD, A_LTS, A_GES, A_LTU, A_GEU};

  // Vector layout: a[20:19] b[18:16] alu[15:11] req we size[8:6] gpr wb ill br jal jalr
  function automatic logic [20:0] mk(input logic [1:0] a, input logic [2:0] b, input logic [4:0] alu,
                                     input logic req, input logic we, input logic [2:0] sz,
                                     input logic gpr, input logic wb, input logic ill,
                                     input logic br, input logic j, input logic jr);
    return {a, b, alu, req, we, sz, gpr, wb, ill, br, j, jr};
  endfunction

  localparam logic [20:0] DEF = {2'd0, 3'd1, 5'd0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] ILL = {2'd0, 3'd1, 5'd0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  function automatic logic [20:0] obs0();
    return {if0.ex_op_a_sel_o, if0.ex_op_b_sel_o, if0.alu_op_o, if0.mem_req_o, if0.mem_we_o,
            if0.mem_size_o, if0.gpr_we_a_o, if0.wb_src_sel_o, if0.illegal_instr_o,
            if0.branch_o, if0.jal_o, if0.jalr_o};
  endfunction

  function automatic logic [20:0] obs1();
    return {if1.ex_op_a_sel_o, if1.ex_op_b_sel_o, if1.alu_op_o, if1.mem_req_o, if1.mem_we_o,
            if1.mem_size_o, if1.gpr_we_a_o, if1.wb_src_sel_o, if1.illegal_instr_o,
            if1.branch_o, if1.jal_o, if1.jalr_o};
  endfunction

  // Reference decode, written from the instruction-set rules.
  function automatic logic [20:0] model(input logic [31:0] w);
    logic [4:0] opc; logic [2:0] f3; logic [6:0] f7;
    logic [1:0] a; logic [2:0] b; logic [4:0] alu; logic [2:0] sz;
    logic req, we, gpr, wb, ill, br, j, jr;
    opc = w[6:2]; f3 = w[14:12]; f7 = w[31:25];
    a = 2'd0; b = 3'd1; alu = A_ADD; sz = 3'd2;
    req = 0; we = 0; gpr = 0; wb = 0; ill = 0; br = 0; j = 0; jr = 0;
    if (w[1:0] != 2'b11) ill = 1;
    else if (opc == 5'h00) begin
      req = 1; sz = f3; gpr = 1; wb = 1; ill = (f3 == 3) || (f3 == 6) || (f3 == 7);
    end else if (opc == 5'h08) begin
      b = 3; req = 1; we = 1; sz = f3; ill = (f3 > 2);
    end else if (opc == 5'h04) begin
      gpr = 1; alu = BASE_TBL[f3];
      if (f3 == 1) ill = (f7 != 0);
      else if (f3 == 5) begin
        if (f7 == 7'h20) alu = A_SRA;
        else ill = (f7 != 0);
      end
    end else if (opc == 5'h0C) begin
      b = 0; gpr = 1;
      if (f7 == 0) alu = BASE_TBL[f3];
      else if (f7 == 7'h20 && f3 == 0) alu = A_SUB;
      else if (f7 == 7'h20 && f3 == 5) alu = A_SRA;
      else ill = 1;
    end else if (opc == 5'h0D) begin
      a = 2; b = 2; gpr = 1;
    end else if (opc == 5'h05) begin
      a = 1; b = 2; gpr = 1;
    end else if (opc == 5'h18) begin
      b = 0; br = 1; alu = BR_TBL[f3]; ill = (f3 == 2) || (f3 == 3);
    end else if (opc == 5'h1B) begin
      a = 1; b = 4; gpr = 1; j = 1;
    end else if (opc == 5'h19) begin
      a = 1; b = 4; gpr = 1; jr = 1; ill = (f3 != 0);
    end else if (opc == 5'h03 || opc == 5'h1C) begin
      ill = 0;
    end else ill = 1;
    if (ill) return ILL;
    return {a, b, alu, req, we, sz, gpr, wb, ill, br, j, jr};
  endfunction

  function automatic bit legal_enc(input logic [20:0] v);
    return !$isunknown(v) && (v[20:19] <= 2) && (v[18:16] <= 4) &&
           (v[8:6] inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) &&
           (v[15:11] inside {A_ADD, A_SUB, A_XOR, A_OR, A_AND, A_SRA, A_SRL, A_SLL,
                             A_LTS, A_LTU, A_GES, A_GEU, A_EQ, A_NE, A_SLTS, A_SLTU});
  endfunction

  task automatic drive(input logic [31:0] ins);
    if0.fetched_instr_i = ins;
    if1.fetched_instr_i = ins;
  endtask

  task automatic test_reset();
    logic [20:0] got;
    logic [20:0] lw_exp;
    lw_exp = mk(0, 1, A_ADD, 1, 0, 2, 1, 1, 0, 0, 0, 0);
    @(negedge clk_i); rst_i = 1'b1; drive(32'h0000A103);
    @(posedge clk_i); #1;
    got = obs1(); n_total++;
    if (got !== DEF) $display("FAIL reset_lw got=%h exp=%h", got, DEF); else n_pass++;
    got = obs0(); n_total++;
    if (got !== lw_exp) $display("FAIL reset_comb_unaffected got=%h exp=%h", got, lw_exp); else n_pass++;
    @(negedge clk_i); drive(32'h00000000);
    @(posedge clk_i); #1;
    got = obs1(); n_total++;
    if (got !== DEF) $display("FAIL reset_illegal got=%h exp=%h", got, DEF); else n_pass++;
    @(negedge clk_i); rst_i = 1'b0; drive(32'h0000A103);
    #1; got = obs1(); n_total++;
    if (got !== DEF) $display("FAIL reset_release_hold got=%h exp=%h", got, DEF); else n_pass++;
    @(posedge clk_i); #1;
    got = obs1(); n_total++;
    if (got !== lw_exp) $display("FAIL reset_release_lw got=%h exp=%h", got, lw_exp); else n_pass++;
  endtask

  task automatic test_directed();
    logic [31:0] ins [28];
    logic [20:0] exp [28];
    logic [20:0] got;
    ins[0]  = 32'h00500093; exp[0]  = mk(0, 1, A_ADD, 0, 0, 2, 1, 0, 0, 0, 0, 0);
    ins[1]  = 32'h0000A103; exp[1]  = mk(0, 1, A_ADD, 1, 0, 2, 1, 1, 0, 0, 0, 0);
    ins[2]  = 32'h0000B103; exp[2]  = ILL;
    ins[3]  = 32'h0020A023; exp[3]  = mk(0, 3, A_ADD, 1, 1, 2, 0, 0, 0, 0, 0, 0);
    ins[4]  = 32'h40208033; exp[4]  = mk(0, 0, A_SUB, 0, 0, 2, 1, 0, 0, 0, 0, 0);
    ins[5]  = 32'h02208033; exp[5]  = ILL;
    ins[6]  = 32'h00208463; exp[6]  = mk(0, 0, A_EQ, 0, 0, 2, 0, 0, 0, 1, 0, 0);
    ins[7]  = 32'h0020A463; exp[7]  = ILL;
    ins[8]  = 32'h008000EF; exp[8]  = mk(1, 4, A_ADD, 0, 0, 2, 1, 0, 0, 0, 1, 0);
    ins[9]  = 32'h00008067; exp[9]  = mk(1, 4, A_ADD, 0, 0, 2, 1, 0, 0, 0, 0, 1);
    ins[10] = 32'h0000106F; exp[10] = mk(1, 4, A_ADD, 0, 0, 2, 1, 0, 0, 0, 1, 0);
    ins[11] = 32'h00000000; exp[11] = ILL;
    ins[12] = 32'h40005093; exp[12] = mk(0, 1, A_SRA, 0, 0, 2, 1, 0, 0, 0, 0, 0);
    ins[13] = 32'h40001093; exp[13] = ILL;
    ins[14] = 32'h000010B7; exp[14] = mk(2, 2, A_ADD, 0, 0, 2, 1, 0, 0, 0, 0, 0);
    ins[15] = 32'h00001097; exp[15] = mk(1, 2, A_ADD, 0, 0, 2, 1, 0, 0, 0, 0, 0);
    ins[16] = 32'h0000C103; exp[16] = mk(0, 1, A_ADD, 1, 0, 4, 1, 1, 0, 0, 0, 0);
    ins[17] = 32'h0020F463; exp[17] = mk(0, 0, A_GEU, 0, 0, 2, 0, 0, 0, 1, 0, 0);
    ins[18] = 32'h0000000F; exp[18] = DEF;
    ins[19] = 32'h00000073; exp[19] = DEF;
    ins[20] = 32'h00500091; exp[20] = ILL;
    ins[21] = 32'h0000100F; exp[21] = DEF;
    ins[22] = 32'h00209023; exp[22] = mk(0, 3, A_ADD, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    ins[23] = 32'h0020B023; exp[23] = ILL;
    ins[24] = 32'h00009067; exp[24] = ILL;
    ins[25] = 32'h0020C033; exp[25] = mk(0, 0, A_XOR, 0, 0, 2, 1, 0, 0, 0, 0, 0);
    ins[26] = 32'h4020D033; exp[26] = mk(0, 0, A_SRA, 0, 0, 2, 1, 0, 0, 0, 0, 0);
    ins[27] = 32'h40209033; exp[27] = ILL;
    for (int i = 0; i < 28; i++) begin
      drive(ins[i]); #1;
      got = obs0(); n_total++;
      if (got !== exp[i]) $display("FAIL directed[%0d] ins=%h got=%h exp=%h", i, ins[i], got, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [5];
    logic [20:0] got;
    logic [20:0] prev;
    seq[0] = 32'h00500093; seq[1] = 32'h0020A023; seq[2] = 32'h00000000;
    seq[3] = 32'h00208463; seq[4] = 32'h008000EF;
    @(negedge clk_i); drive(seq[0]);
    @(posedge clk_i); #1;
    prev = model(seq[0]);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk_i); drive(seq[i]); #1;
      got = obs1(); n_total++;
      if (got !== prev) $display("FAIL b2b_hold[%0d] got=%h exp=%h", i, got, prev); else n_pass++;
      @(posedge clk_i); #1;
      prev = model(seq[i]);
      got = obs1(); n_total++;
      if (got !== prev) $display("FAIL b2b_update[%0d] got=%h exp=%h", i, got, prev); else n_pass++;
    end
  endtask

  task automatic test_sweep();
    logic [31:0] w;
    logic [20:0] got0;
    logic [20:0] got1;
    logic [20:0] exp;
    for (int k = 0; k < 3300; k++) begin
      w = $urandom();
      if (k < 3200) w = {w[31:7], 5'(k / 100), 2'b11};
      @(negedge clk_i); drive(w); #1;
      exp = model(w);
      got0 = obs0(); n_total++;
      if (got0 !== exp) $display("FAIL sweep_comb ins=%h got=%h exp=%h", w, got0, exp); else n_pass++;
      n_total++;
      if (!legal_enc(got0)) $display("FAIL sweep_encoding ins=%h got=%h exp=legal", w, got0); else n_pass++;
      @(posedge clk_i); #1;
      got1 = obs1(); n_total++;
      if (got1 !== exp) $display("FAIL sweep_reg ins=%h got=%h exp=%h", w, got1, exp); else n_pass++;
    end
  endtask

  initial begin
    drive(32'h00000013);
    repeat (2) @(posedge clk_i);
    test_reset();
    test_directed();
    test_back_to_back();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
